// File: rtl/vec_operand_aligner_pkg.sv
// Shared types and sizing for the vector operand aligner.
// Lane entries carry {tlast, data}.
package vec_operand_aligner_pkg;

  localparam int VA_LANES = 16;
  localparam int VA_LW    = 32;
  localparam int VA_PHIT  = VA_LANES * VA_LW;
  localparam int VA_DEPTH = 4;
  localparam int VA_CNT_W = $clog2(VA_DEPTH) + 1;

  typedef struct packed {
    logic             tlast;
    logic [VA_LW-1:0] data;
  } lane_entry_t;

endpackage

// File: rtl/vec_operand_aligner_lane_fifo.sv
// Single-lane FIFO with occupancy count, full and empty flags.
// Flush clears pointers and count; pointers wrap modulo DEPTH.
module vec_operand_aligner_lane_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/vec_operand_aligner.sv
// Pairs per-lane A/B operands so each PE lane sees both valids together.
// Define VEC_ALIGN_BYPASS_EN for a 1-cycle path when both lane FIFOs are empty.
module vec_operand_aligner
  import vec_operand_aligner_pkg::*;
#(
  parameter int LANES = VA_LANES,
  parameter int LW    = VA_LW,
  parameter int DEPTH = VA_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic [LANES*LW-1:0] s_a_tdata,
  input  logic [LANES-1:0]    s_a_tvalid,
  input  logic [LANES-1:0]    s_a_tlast,
  output logic                s_a_tready,
  input  logic [LANES*LW-1:0] s_b_tdata,
  input  logic [LANES-1:0]    s_b_tvalid,
  input  logic [LANES-1:0]    s_b_tlast,
  output logic                s_b_tready,
  output logic [LANES*LW-1:0] o_a_data,
  output logic [LANES*LW-1:0] o_b_data,
  output logic [LANES-1:0]    o_tvalid1,
  output logic [LANES-1:0]    o_tvalid2,
  output logic [LANES-1:0]    o_tlast1,
  output logic [LANES-1:0]    o_tlast2,
  output logic                o_err_tlast
);

  localparam int CW = $clog2(DEPTH) + 1;

  lane_entry_t [LANES-1:0] w_a_in;
  lane_entry_t [LANES-1:0] w_b_in;
  lane_entry_t [LANES-1:0] w_a_head;
  lane_entry_t [LANES-1:0] w_b_head;
  lane_entry_t [LANES-1:0] w_a_sel;
  lane_entry_t [LANES-1:0] w_b_sel;

  logic [LANES-1:0][CW-1:0] w_a_cnt;
  logic [LANES-1:0][CW-1:0] w_b_cnt;
  logic [LANES-1:0] w_a_full;
  logic [LANES-1:0] w_b_full;
  logic [LANES-1:0] w_a_empty;
  logic [LANES-1:0] w_b_empty;
  logic [LANES-1:0] w_a_take;
  logic [LANES-1:0] w_b_take;
  logic [LANES-1:0] w_a_push;
  logic [LANES-1:0] w_b_push;
  logic [LANES-1:0] w_pop;
  logic [LANES-1:0] w_sel;
  logic             w_a_rdy;
  logic             w_b_rdy;
  logic             w_mis;
  logic             w_unused_cnt;

  logic [LANES*LW-1:0] w_a_nxt;
  logic [LANES*LW-1:0] w_b_nxt;
  logic [LANES-1:0]    w_l1_nxt;
  logic [LANES-1:0]    w_l2_nxt;

  logic                r_rdy_en;
  logic [LANES*LW-1:0] r_a_data;
  logic [LANES*LW-1:0] r_b_data;
  logic [LANES-1:0]    r_tvalid;
  logic [LANES-1:0]    r_tlast1;
  logic [LANES-1:0]    r_tlast2;
  logic                r_err;

  // Ready comes only from registered state, never from tvalid.
  assign w_a_rdy    = r_rdy_en & ~|w_a_full;
  assign w_b_rdy    = r_rdy_en & ~|w_b_full;
  assign s_a_tready = w_a_rdy;
  assign s_b_tready = w_b_rdy;

  assign w_a_take = s_a_tvalid & {LANES{w_a_rdy & ~i_flush}};
  assign w_b_take = s_b_tvalid & {LANES{w_b_rdy & ~i_flush}};
  assign w_pop    = ~w_a_empty & ~w_b_empty;
  assign w_unused_cnt = ^{w_a_cnt, w_b_cnt};

`ifdef VEC_ALIGN_BYPASS_EN
  logic [LANES-1:0] w_byp;
  assign w_byp    = w_a_take & w_b_take & w_a_empty & w_b_empty;
  assign w_a_push = w_a_take & ~w_byp;
  assign w_b_push = w_b_take & ~w_byp;
`else
  assign w_a_push = w_a_take;
  assign w_b_push = w_b_take;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_a_in[g] = '{tlast: s_a_tlast[g], data: s_a_tdata[g*LW +: LW]};
    assign w_b_in[g] = '{tlast: s_b_tlast[g], data: s_b_tdata[g*LW +: LW]};

    vec_operand_aligner_lane_fifo #(
      .W     ($bits(lane_entry_t)),
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_fifo_a (
      .clk     (clk),
      .rst_n   (rst),
      .i_flush (i_flush),
      .i_push  (w_a_push[g]),
      .i_pop   (w_pop[g]),
      .i_data  (w_a_in[g]),
      .o_data  (w_a_head[g]),
      .o_count (w_a_cnt[g]),
      .o_full  (w_a_full[g]),
      .o_empty (w_a_empty[g])
    );

    vec_operand_aligner_lane_fifo #(
      .W     ($bits(lane_entry_t)),
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_fifo_b (
      .clk     (clk),
      .rst_n   (rst),
      .i_flush (i_flush),
      .i_push  (w_b_push[g]),
      .i_pop   (w_pop[g]),
      .i_data  (w_b_in[g]),
      .o_data  (w_b_head[g]),
      .o_count (w_b_cnt[g]),
      .o_full  (w_b_full[g]),
      .o_empty (w_b_empty[g])
    );
  end

  always_comb begin
    w_sel   = w_pop;
    w_a_sel = w_a_head;
    w_b_sel = w_b_head;
`ifdef VEC_ALIGN_BYPASS_EN
    w_sel = w_pop | w_byp;
    for (int l = 0; l < LANES; l++) begin
      if (w_byp[l]) begin
        w_a_sel[l] = w_a_in[l];
        w_b_sel[l] = w_b_in[l];
      end
    end
`endif
    w_a_nxt  = '0;
    w_b_nxt  = '0;
    w_l1_nxt = '0;
    w_l2_nxt = '0;
    w_mis    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (w_sel[l]) begin
        w_a_nxt[l*LW +: LW] = w_a_sel[l].data;
        w_b_nxt[l*LW +: LW] = w_b_sel[l].data;
        w_l1_nxt[l] = w_a_sel[l].tlast;
        w_l2_nxt[l] = w_b_sel[l].tlast;
        if (w_a_sel[l].tlast != w_b_sel[l].tlast) w_mis = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_en <= 1'b0;
      r_a_data <= '0;
      r_b_data <= '0;
      r_tvalid <= '0;
      r_tlast1 <= '0;
      r_tlast2 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (i_flush) begin
        r_a_data <= '0;
        r_b_data <= '0;
        r_tvalid <= '0;
        r_tlast1 <= '0;
        r_tlast2 <= '0;
        r_err    <= 1'b0;
      end else begin
        r_a_data <= w_a_nxt;
        r_b_data <= w_b_nxt;
        r_tvalid <= w_sel;
        r_tlast1 <= w_l1_nxt;
        r_tlast2 <= w_l2_nxt;
        if (w_mis) r_err <= 1'b1;
      end
    end
  end

  assign o_a_data    = r_a_data;
  assign o_b_data    = r_b_data;
  assign o_tvalid1   = r_tvalid;
  assign o_tvalid2   = r_tvalid;
  assign o_tlast1    = r_tlast1;
  assign o_tlast2    = r_tlast2;
  assign o_err_tlast = r_err;

endmodule

// File: tb/tb_vec_operand_aligner.sv
// Self-checking bench for vec_operand_aligner: directed steps then random traffic,
// compared against per-lane queue model of the pairing rules.
module tb_vec_operand_aligner;

  localparam int L  = 16;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int NB = L * W;
`ifdef VEC_ALIGN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [NB-1:0] a_data = '0;
  logic [NB-1:0] b_data = '0;
  logic [L-1:0]  a_val = '0;
  logic [L-1:0]  a_last = '0;
  logic [L-1:0]  b_val = '0;
  logic [L-1:0]  b_last = '0;

  logic          s_a_tready;
  logic          s_b_tready;
  logic [NB-1:0] o_a_data;
  logic [NB-1:0] o_b_data;
  logic [L-1:0]  o_tvalid1;
  logic [L-1:0]  o_tvalid2;
  logic [L-1:0]  o_tlast1;
  logic [L-1:0]  o_tlast2;
  logic          o_err_tlast;

  always #5 clk = ~clk;

  vec_operand_aligner dut (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .s_a_tdata   (a_data),
    .s_a_tvalid  (a_val),
    .s_a_tlast   (a_last),
    .s_a_tready  (s_a_tready),
    .s_b_tdata   (b_data),
    .s_b_tvalid  (b_val),
    .s_b_tlast   (b_last),
    .s_b_tready  (s_b_tready),
    .o_a_data    (o_a_data),
    .o_b_data    (o_b_data),
    .o_tvalid1   (o_tvalid1),
    .o_tvalid2   (o_tvalid2),
    .o_tlast1    (o_tlast1),
    .o_tlast2    (o_tlast2),
    .o_err_tlast (o_err_tlast)
  );

  logic [W:0] qa [L][$];
  logic [W:0] qb [L][$];
  bit m_rdy = 1'b0;
  bit m_err = 1'b0;
  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [NB-1:0] obs,
                     input logic [NB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < L; l++) begin
      qa[l].delete();
      qb[l].delete();
    end
    m_err = 1'b0;
  endtask

  task automatic rnd_data();
    for (int l = 0; l < L; l++) begin
      a_data[l*W +: W] = $urandom;
      b_data[l*W +: W] = $urandom;
    end
  endtask

  // One clock: predict from queues, advance clock, compare registered outputs.
  task automatic cycle();
    bit ra, rb, pa, pb;
    logic [W:0] ea, eb, ia, ib;
    logic [NB-1:0] e_a, e_b;
    logic [L-1:0] e_v, e_l1, e_l2;
    ra = m_rdy;
    rb = m_rdy;
    for (int l = 0; l < L; l++) begin
      if (qa[l].size() >= D) ra = 1'b0;
      if (qb[l].size() >= D) rb = 1'b0;
    end
    chk("tready_a", NB'(s_a_tready), NB'(ra));
    chk("tready_b", NB'(s_b_tready), NB'(rb));
    e_a = '0; e_b = '0; e_v = '0; e_l1 = '0; e_l2 = '0;
    for (int l = 0; l < L; l++) begin
      ia = {a_last[l], a_data[l*W +: W]};
      ib = {b_last[l], b_data[l*W +: W]};
      pa = a_val[l] && ra && !flush;
      pb = b_val[l] && rb && !flush;
      ea = '0;
      eb = '0;
      if (!flush) begin
        if (qa[l].size() > 0 && qb[l].size() > 0) begin
          ea = qa[l].pop_front();
          eb = qb[l].pop_front();
          e_v[l] = 1'b1;
        end else if (BYP && qa[l].size() == 0 && qb[l].size() == 0 && pa && pb) begin
          ea = ia;
          eb = ib;
          e_v[l] = 1'b1;
          pa = 1'b0;
          pb = 1'b0;
        end
        if (e_v[l]) begin
          e_a[l*W +: W] = ea[W-1:0];
          e_b[l*W +: W] = eb[W-1:0];
          e_l1[l] = ea[W];
          e_l2[l] = eb[W];
          if (ea[W] != eb[W]) m_err = 1'b1;
        end
        if (pa) qa[l].push_back(ia);
        if (pb) qb[l].push_back(ib);
      end
    end
    if (flush) model_clear();
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    chk("tvalid1", NB'(o_tvalid1), NB'(e_v));
    chk("tvalid2", NB'(o_tvalid2), NB'(e_v));
    chk("a_data", o_a_data, e_a);
    chk("b_data", o_b_data, e_b);
    chk("tlast1", NB'(o_tlast1), NB'(e_l1));
    chk("tlast2", NB'(o_tlast2), NB'(e_l2));
    chk("err_tlast", NB'(o_err_tlast), NB'(m_err));
  endtask

  initial begin
    // Reset and release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", NB'(o_tvalid1), '0);
    chk("rst_a_data", o_a_data, '0);
    chk("rst_b_data", o_b_data, '0);
    chk("rst_err", NB'(o_err_tlast), '0);
    chk("rst_tready_a", NB'(s_a_tready), '0);
    chk("rst_tready_b", NB'(s_b_tready), '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_tready_pre_edge", NB'(s_a_tready), '0);
    cycle();
    chk("rel_tready_post_edge", NB'(s_a_tready), NB'(1));

    // Single lane-0 pair: latency 2 (1 with bypass).
    a_data[31:0] = 32'h3F80_0000;
    b_data[31:0] = 32'h4000_0000;
    a_val = 16'h0001;
    b_val = 16'h0001;
    cycle();
    a_val = '0;
    b_val = '0;
    chk("t2_n1_valid", NB'(o_tvalid1[0]), NB'(BYP ? 1 : 0));
    chk("t2_n1_a", NB'(o_a_data[31:0]), NB'(BYP ? 32'h3F80_0000 : 32'h0));
    cycle();
    chk("t2_n2_valid", NB'(o_tvalid1[0]), NB'(BYP ? 0 : 1));
    chk("t2_n2_a", NB'(o_a_data[31:0]), NB'(BYP ? 32'h0 : 32'h3F80_0000));
    chk("t2_n2_b", NB'(o_b_data[31:0]), NB'(BYP ? 32'h0 : 32'h4000_0000));
    cycle();
    chk("t2_n3_valid", NB'(o_tvalid1[0]), '0);

    // Skew: 4 beats of A fill the FIFOs, then 4 beats of B drain them.
    a_last = '0;
    b_last = '0;
    for (int k = 0; k < 4; k++) begin
      rnd_data();
      a_val = '1;
      cycle();
    end
    a_val = '0;
    chk("t3_a_full", NB'(s_a_tready), '0);
    chk("t3_b_ready", NB'(s_b_tready), NB'(1));
    for (int k = 0; k < 4; k++) begin
      rnd_data();
      b_val = '1;
      cycle();
    end
    b_val = '0;
    repeat (3) cycle();
    chk("t3_a_back", NB'(s_a_tready), NB'(1));

    // tlast mismatch on lane 3, then flush.
    rnd_data();
    a_val = 16'h0008;
    b_val = 16'h0008;
    a_last = 16'h0008;
    b_last = 16'h0000;
    cycle();
    a_val = '0;
    b_val = '0;
    a_last = '0;
    repeat (2) cycle();
    chk("t4_err_set", NB'(o_err_tlast), NB'(1));
    repeat (2) cycle();
    chk("t4_err_hold", NB'(o_err_tlast), NB'(1));
    for (int k = 0; k < 2; k++) begin
      rnd_data();
      a_val = '1;
      cycle();
    end
    a_val = '0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t4_err_clear", NB'(o_err_tlast), '0);
    for (int k = 0; k < 2; k++) begin
      rnd_data();
      b_val = '1;
      cycle();
    end
    b_val = '0;
    repeat (2) cycle();
    chk("t4_no_stale", NB'(o_tvalid1), '0);

    // Reset mid-stream with entries pending.
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rnd_data();
      a_val = '1;
      b_val = (k >= 2) ? '1 : '0;
      cycle();
    end
    a_val = '0;
    b_val = '0;
    chk("t5_live_before_rst", NB'(o_tvalid1), NB'(16'hFFFF));
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_tvalid", NB'(o_tvalid1), '0);
    chk("t5_rst_a_data", o_a_data, '0);
    chk("t5_rst_b_data", o_b_data, '0);
    chk("t5_rst_tready", NB'(s_a_tready), '0);
    model_clear();
    m_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) cycle();

    // Random per-lane traffic.
    for (int k = 0; k < 10000; k++) begin
      rnd_data();
      a_val  = 16'($urandom);
      b_val  = 16'($urandom);
      a_last = 16'($urandom);
      b_last = 16'($urandom);
      flush  = ($urandom_range(0, 499) == 0);
      cycle();
    end
    a_val = '0;
    b_val = '0;
    flush = 1'b0;
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_operand_aligner.md
Name: vec_operand_aligner

Overview:
- Sits directly upstream of the vectorized floating-point PE array.
- Takes two independent per-lane-valid vector streams (operand A, operand B) and buffers each lane in small FIFOs.
- Emits a lane only when both operands for that lane are present, so every PE lane sees i_tvalid1 and i_tvalid2 asserted together and never falls back to its nop path mid-stream.
- Provides stream-level backpressure (tready) to the upstream producers.

Parameters:
- LANES, SIMD_degree (16), number of lanes.
- LW, dwidth_float (32), bits per lane.
- DEPTH, 4, entries per lane FIFO; power of two, at least 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous clear of all FIFOs and output register.
- s_a_tdata  in  LANES*LW  operand A, lane i at [(i+1)*LW-1 : i*LW].
- s_a_tvalid  in  LANES  per-lane valid, A.
- s_a_tlast  in  LANES  per-lane last, A.
- s_a_tready  out  1  A accepted this cycle.
- s_b_tdata / s_b_tvalid / s_b_tlast / s_b_tready  same as A, for operand B.
- o_a_data  out  LANES*LW  to PE i1.
- o_b_data  out  LANES*LW  to PE i2.
- o_tvalid1  out  LANES  to PE tvalid1.
- o_tvalid2  out  LANES  to PE tvalid2; always equal to o_tvalid1.
- o_tlast1  out  LANES  last of A.
- o_tlast2  out  LANES  last of B.
- o_err_tlast  out  1  sticky tlast-mismatch flag.

Behaviour:
- Reset (rst=0, async):
  - All FIFOs are emptied and counts cleared.
  - o_* data, tvalid and tlast outputs are 0; o_err_tlast is 0.
  - s_a_tready and s_b_tready are 0 while rst=0, and equal 1 from the first clk edge after release.
- Per lane, per stream: one FIFO of DEPTH entries holding {tlast, data}, with a count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- s_x_tready is 1 iff no lane FIFO of stream x is full. It is driven from registered counts (no combinational path from tvalid).
- Write: lane i of stream x is pushed iff s_x_tvalid[i] && s_x_tready. Lanes with tvalid=0 are not written.
- Pop: lane i pops A and B together iff both lane-i FIFOs are non-empty, based on registered counts.
- Output register, loaded every cycle:
  - Popped lane: data, tlast and tvalid1=tvalid2=1.
  - Non-popped lane: tvalid=0, data=0, tlast=0.
  - Each output holds for exactly one cycle; the PE has no ready, so there is no downstream stall.
- Latency: write at cycle N, with the partner lane already present, appears on outputs at N+2.
- Throughput: 1 pair per lane per cycle sustained.
- Same-cycle push and pop on a lane: count unchanged, both take effect.
  - A push onto a full FIFO cannot occur, because tready=0.
  - A pop from an empty FIFO cannot occur.
- tlast mismatch: if a popped pair has tlast A != tlast B, o_err_tlast is set to 1 and stays set until reset or i_flush. The data is still emitted.
- i_flush=1:
  - At the next edge, all counts and pointers go to 0, the output register clears, and o_err_tlast clears.
  - Writes in the flush cycle are dropped; tready stays 1 if not full.
- Lanes are fully independent; lane skew up to DEPTH beats is absorbed.

Optional Feature:
- Macro: VEC_ALIGN_BYPASS_EN.
- When defined: if both lane-i FIFOs are empty and both streams push lane i in the same cycle, the inputs go straight to the output register. The FIFOs are not written, counts are unchanged, and latency is 1.
- When undefined: latency is always 2 and there is no bypass mux.

Decomposition:
- LANES, LW and phit_size come from the shared interface header.
- A lane_entry_t typedef (tlast + data) and an aligner count-width constant go in the shared package.
- Sub-module lane_fifo: one single-lane FIFO with count, full and empty outputs. It is instantiated 2*LANES times by generate.

Test Plan:
1. Reset then release. All outputs are 0. Tready is 0 during reset and 1 one edge after release.
2. Lane 0: A=0x3F800000 at cycle 5, B=0x40000000 at cycle 5. At cycle 7: o_tvalid1[0]=o_tvalid2[0]=1, o_a_data lane0=0x3F800000, o_b_data lane0=0x40000000. At cycle 6 and cycle 8 they are 0. With VEC_ALIGN_BYPASS_EN the pair appears at cycle 6.
3. Skew: push A on all lanes for 4 beats with no B. s_a_tready falls to 0 after the 4th push while s_b_tready stays 1. Then push B for 4 beats. Outputs are 4 aligned pairs in order, and s_a_tready returns to 1.
4. Push lane 3 A with tlast=1 and lane 3 B with tlast=0. On the emitted pair, o_err_tlast=1 and stays set. i_flush clears it to 0 and empties all FIFOs.
5. Assert rst mid-stream with 2 entries pending per lane. Outputs clear immediately with no clock. After release no stale pairs emerge.
6. Random per-lane tvalid on A and B for 10k cycles. The scoreboard checks per-lane FIFO order, and that o_tvalid1==o_tvalid2 holds every cycle.
